// File: rtl/config_pkg.sv
// Minimal core-configuration package: carries the virtual address width used for
// return addresses.
package config_pkg;

    typedef struct packed {
        int unsigned VLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd32};

endpackage

// File: rtl/ras_ctrl_pkg.sv
// Shared types for the return-address-stack repair controller.
package ras_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        REPLAY = 2'd2
    } ras_ctrl_state_e;

    // Replay index width; supports stacks of up to 2**RAS_CTRL_IDX_W entries.
    localparam int unsigned RAS_CTRL_IDX_W = 4;
    localparam int unsigned RAS_CTRL_CNT_W = RAS_CTRL_IDX_W + 1;

    typedef logic [RAS_CTRL_IDX_W-1:0] ras_ctrl_idx_t;
    typedef logic [RAS_CTRL_CNT_W-1:0] ras_ctrl_cnt_t;

endpackage

// File: rtl/ras_commit_stack.sv
// Committed (architectural) shadow copy of the return address stack.
// Entry 0 is the top; current and next-cycle contents are both exposed in parallel.
module ras_commit_stack #(
    parameter type         ras_t = logic,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clear_i,
    input  logic            valid_i,
    input  logic            call_i,
    input  logic            ret_i,
    input  logic [VLEN-1:0] ra_i,
    output ras_t            entries_o     [DEPTH],
    output ras_t            entries_nxt_o [DEPTH]
);

    ras_t stack_q [DEPTH];
    ras_t stack_d [DEPTH];

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            stack_d[i] = stack_q[i];
        end
        if (clear_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_d[i] = '0;
            end
        end else if (valid_i) begin
            if (call_i && ret_i) begin
                stack_d[0].ra    = ra_i;
                stack_d[0].valid = 1'b1;
            end else if (call_i) begin
                for (int i = int'(DEPTH) - 1; i > 0; i--) begin
                    stack_d[i] = stack_q[i-1];
                end
                stack_d[0].ra    = ra_i;
                stack_d[0].valid = 1'b1;
            end else if (ret_i) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    stack_d[i] = stack_q[i+1];
                end
                stack_d[DEPTH-1] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign entries_o     = stack_q;
    assign entries_nxt_o = stack_d;

endmodule

// File: rtl/ras_ctrl.sv
// RAS controller: forwards speculative frontend calls/returns to the RAS and, when
// RAS_CTRL_REPAIR_EN is defined, rebuilds it from a committed shadow after a mispredict.
//
//   state  | meaning
//   IDLE   | frontend owns the RAS
//   FLUSH  | one-cycle RAS flush before rebuilding from the snapshot
//   REPLAY | pushing snapshot entries, deepest first, one per cycle
module ras_ctrl
    import ras_ctrl_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type                   ras_t   = logic,
    parameter int unsigned           DEPTH   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    mispredict_i,
    input  logic                    fe_valid_i,
    input  logic                    fe_call_i,
    input  logic                    fe_ret_i,
    input  logic [CVA6Cfg.VLEN-1:0] fe_ra_i,
    output logic                    fe_ready_o,
    input  logic                    cm_valid_i,
    input  logic                    cm_call_i,
    input  logic                    cm_ret_i,
    input  logic [CVA6Cfg.VLEN-1:0] cm_ra_i,
    output logic                    ras_push_o,
    output logic                    ras_pop_o,
    output logic                    ras_flush_o,
    output logic [CVA6Cfg.VLEN-1:0] ras_data_o,
    output logic                    busy_o
);

    localparam int unsigned VLEN = CVA6Cfg.VLEN;

    logic accept;

`ifdef RAS_CTRL_REPAIR_EN

    ras_ctrl_state_e state_q;
    ras_t            shadow     [DEPTH];
    ras_t            shadow_nxt [DEPTH];
    ras_t            snap_q     [DEPTH];
    ras_ctrl_idx_t   idx_q;
    logic            dirty_q;
    ras_ctrl_cnt_t   snap_cnt;
    logic            replay_push;
    logic [VLEN-1:0] replay_data;

    ras_commit_stack #(
        .ras_t (ras_t),
        .DEPTH (DEPTH),
        .VLEN  (VLEN)
    ) i_commit_stack (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (flush_i),
        .valid_i       (cm_valid_i),
        .call_i        (cm_call_i),
        .ret_i         (cm_ret_i),
        .ra_i          (cm_ra_i),
        .entries_o     (shadow),
        .entries_nxt_o (shadow_nxt)
    );

    // Valid entries are contiguous from the top, so the count also locates the deepest one.
    always_comb begin
        snap_cnt    = '0;
        replay_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            snap_cnt = snap_cnt + ras_ctrl_cnt_t'(snap_q[i].valid);
            if (idx_q == ras_ctrl_idx_t'(i)) begin
                replay_data = snap_q[i].ra;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            dirty_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                snap_q[i] <= '0;
            end
        end else if (flush_i) begin
            state_q <= IDLE;
            dirty_q <= 1'b0;
        end else if (mispredict_i) begin
            state_q <= FLUSH;
            dirty_q <= 1'b0;
            snap_q  <= shadow_nxt;
        end else begin
            if (cm_valid_i && state_q != IDLE) begin
                dirty_q <= 1'b1;
            end
            case (state_q)
                FLUSH: begin
                    if (snap_cnt == '0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= REPLAY;
                        idx_q   <= ras_ctrl_idx_t'(snap_cnt - 1'b1);
                    end
                end
                REPLAY: begin
                    if (idx_q == '0) begin
                        // A commit seen during repair makes the rebuilt stack stale: start over.
                        if (dirty_q || cm_valid_i) begin
                            state_q <= FLUSH;
                            snap_q  <= shadow_nxt;
                            dirty_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fe_ready_o  = rst_ni && (state_q == IDLE) && !mispredict_i && !flush_i;
    assign accept      = fe_ready_o && fe_valid_i;
    assign replay_push = rst_ni && (state_q == REPLAY) && !mispredict_i && !flush_i;
    assign ras_push_o  = (accept && fe_call_i) || replay_push;
    assign ras_pop_o   = accept && fe_ret_i;
    assign ras_flush_o = rst_ni && (flush_i || state_q == FLUSH);
    assign ras_data_o  = accept ? fe_ra_i : (replay_push ? replay_data : '0);
    assign busy_o      = (state_q != IDLE);

`else

    logic unused_repair;
    assign unused_repair = ^{clk_i, cm_valid_i, cm_call_i, cm_ret_i, cm_ra_i};

    assign fe_ready_o  = rst_ni && !mispredict_i && !flush_i;
    assign accept      = fe_ready_o && fe_valid_i;
    assign ras_push_o  = accept && fe_call_i;
    assign ras_pop_o   = accept && fe_ret_i;
    assign ras_flush_o = rst_ni && (flush_i || mispredict_i);
    assign ras_data_o  = accept ? fe_ra_i : '0;
    assign busy_o      = 1'b0;

`endif

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty; core configuration, VLEN taken from it.
REQ-002 Parameter ras_t, default logic; RAS entry type with fields ra (VLEN) and valid (1).
REQ-003 Parameter DEPTH, default 2; number of RAS entries, shared with the controlled RAS.
REQ-004 clk_i  in  1  clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 flush_i  in  1  full branch-predictor flush.
REQ-007 mispredict_i  in  1  resolved control-flow mispredict; speculative RAS state is invalid.
REQ-008 fe_valid_i / fe_call_i / fe_ret_i  in  1 each  speculative frontend call/return request.
REQ-009 fe_ra_i  in  VLEN  return address to push on a frontend call.
REQ-010 fe_ready_o  out  1  frontend request accepted this cycle.
REQ-011 cm_valid_i / cm_call_i / cm_ret_i  in  1 each  committed call/return.
REQ-012 cm_ra_i  in  VLEN  committed return address.
REQ-013 ras_push_o / ras_pop_o / ras_flush_o  out  1 each  RAS push, pop, flush.
REQ-014 ras_data_o  out  VLEN  RAS push data.
REQ-015 busy_o  out  1  repair in progress.

Function
REQ-016 The FSM SHALL have three states: IDLE, FLUSH, REPLAY.
REQ-017 fe_ready_o SHALL equal (state==IDLE) && !mispredict_i && !flush_i.
REQ-018 In IDLE, an accepted request SHALL drive ras_push_o=fe_call_i, ras_pop_o=fe_ret_i and ras_data_o=fe_ra_i in the same cycle (zero latency); call+ret together SHALL drive both, so the top entry is replaced.
REQ-019 Each cm_valid_i beat SHALL update the shadow stack in every state, using the RAS semantics: call pushes, ret pops and zero-fills the bottom, call+ret replaces the top.
REQ-020 Priority SHALL be flush_i > mispredict_i > frontend.
REQ-021 flush_i SHALL assert ras_flush_o that cycle, clear the shadow stack and the dirty flag, and go to IDLE from any state.
REQ-022 mispredict_i in any state SHALL go to FLUSH, latch the shadow stack into a replay snapshot, and clear dirty.
REQ-023 FLUSH SHALL assert ras_flush_o for exactly one cycle, then go to REPLAY, or to IDLE if the snapshot holds no valid entries.
REQ-024 REPLAY SHALL push the valid snapshot entries one per cycle, deepest valid entry first, with ras_data_o set to the entry ra, and SHALL never assert ras_pop_o.
REQ-025 After the last push, REPLAY SHALL go to IDLE if dirty=0, or to FLUSH with a fresh snapshot if dirty=1.
REQ-026 dirty SHALL set on any cm_valid_i beat while the state is FLUSH or REPLAY.
REQ-027 busy_o SHALL equal (state != IDLE).
REQ-028 A repair with V valid entries SHALL take 1+V cycles.

Reset
REQ-029 On reset: state=IDLE, shadow stack and snapshot all zero, dirty=0.
REQ-030 During reset, ras_push_o, ras_pop_o, ras_flush_o, busy_o and ras_data_o SHALL be 0, and fe_ready_o SHALL be 1 once rst_ni deasserts.
REQ-031 Reset mid-repair SHALL abort the repair with no further pushes.

Configuration
REQ-032 Macro RAS_CTRL_REPAIR_EN defined: full shadow/replay repair as specified above.
REQ-033 Macro undefined: no shadow stack, snapshot or FSM storage; mispredict_i asserts ras_flush_o for one cycle; cm_* are ignored; busy_o=0; fe_ready_o=!mispredict_i && !flush_i.

Structure
REQ-034 The state enum ras_ctrl_state_e and the replay-index width constant SHALL live in ras_ctrl_pkg.
REQ-035 The shadow stack SHALL be a sub-module ras_commit_stack (DEPTH entries of ras_t) that exposes all entries in parallel.

Verification
REQ-036 DEPTH=4: frontend call ra=0x100 -> ras_push_o=1 and ras_data_o=0x100 in the same cycle, fe_ready_o=1.
REQ-037 Commit calls 0x10, 0x20; then mispredict -> ras_flush_o 1 cycle, pushes 0x10 then 0x20, busy_o high exactly 3 cycles.
REQ-038 Empty shadow, mispredict -> one flush cycle, then IDLE; busy_o high 1 cycle; no push.
REQ-039 Commit ret during REPLAY -> repair restarts at FLUSH, and the final RAS contents match the updated shadow.
REQ-040 flush_i during REPLAY -> ras_flush_o=1, IDLE next cycle, shadow empty, no further pushes.
REQ-041 Macro undefined: mispredict -> single ras_flush_o pulse, busy_o stays 0.
